// File: rtl/moore_seq_detect.sv
// Moore sequence detector: tracks how many leading symbols of a reset-captured pattern
// have been seen, with sticky/non-sticky match mode and a saturating match counter.
module moore_seq_detect #(
    parameter int unsigned SYM_W = 2,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned ST_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     step,
    input  logic [SYM_W-1:0]         sym_in,
    input  logic                     hold,
    input  logic [DEPTH*SYM_W-1:0]   pattern_in,
    input  logic [ST_W-1:0]          state_in,
    output logic [ST_W-1:0]          state,
    output logic                     match,
    output logic                     match_pulse,
    output logic [CNT_W-1:0]         match_count,
    output logic                     count_sat
);

    localparam logic [ST_W-1:0]  ST_IDLE = '0;
    localparam logic [ST_W-1:0]  ST_FULL = ST_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DEPTH*SYM_W-1:0] pat_q;
    logic [ST_W-1:0]        state_q, state_d, fallback;
    logic                   match_q, pulse_q, sat_q;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [SYM_W-1:0]       cur_sym;
    logic                   entry;

    // cur_sym is the symbol expected next; in the full state it is the last pattern symbol,
    // which is what the sticky mode compares against.
    always_comb begin
        cur_sym = pat_q[(DEPTH-1)*SYM_W +: SYM_W];
        for (int k = 0; k < DEPTH; k++) begin
            if (state_q == ST_W'(k)) begin
                cur_sym = pat_q[k*SYM_W +: SYM_W];
            end
        end
    end

    always_comb begin
        fallback = (sym_in == pat_q[SYM_W-1:0]) ? ST_W'(1) : ST_IDLE;
        state_d  = state_q;
        if (step) begin
            if (state_q == ST_FULL) begin
                if (hold && (sym_in == cur_sym)) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = fallback;
                end
            end else if (sym_in == cur_sym) begin
                state_d = state_q + ST_W'(1);
            end else begin
                state_d = fallback;
            end
        end
    end

    assign entry   = (state_q != ST_FULL) && (state_d == ST_FULL);
    assign count_d = (entry && (count_q != CNT_MAX)) ? count_q + CNT_W'(1) : count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= pattern_in;
            state_q <= (state_in <= ST_FULL) ? state_in : ST_IDLE;
            match_q <= (state_in == ST_FULL);
            pulse_q <= 1'b0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= (state_d == ST_FULL);
            pulse_q <= entry;
            count_q <= count_d;
            sat_q   <= sat_q | (count_d == CNT_MAX);
        end
    end

    assign state       = state_q;
    assign match       = match_q;
    assign match_pulse = pulse_q;
    assign match_count = count_q;
    assign count_sat   = sat_q;

endmodule

// File: tb/tb_moore_seq_detect.sv
// Directed bench for moore_seq_detect: default instance, a CNT_W=2 instance for saturation,
// and a DEPTH=4 instance whose 3-bit state_in can carry out-of-range load values.
module tb_moore_seq_detect;

    logic       clk = 1'b0;
    logic       reset, step, hold;
    logic [1:0] sym_in;
    logic [5:0] pattern_in;
    logic [1:0] state_in;
    logic [7:0] pattern_in_c;
    logic [2:0] state_in_c;

    logic [1:0] state_a, state_b;
    logic [2:0] state_c;
    logic       match_a, match_b, match_c;
    logic       pulse_a, pulse_b, pulse_c;
    logic [7:0] count_a, count_c;
    logic [1:0] count_b;
    logic       sat_a, sat_b, sat_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    moore_seq_detect #(.SYM_W(2), .DEPTH(3), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .step(step), .sym_in(sym_in), .hold(hold),
        .pattern_in(pattern_in), .state_in(state_in), .state(state_a), .match(match_a),
        .match_pulse(pulse_a), .match_count(count_a), .count_sat(sat_a)
    );

    moore_seq_detect #(.SYM_W(2), .DEPTH(3), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .step(step), .sym_in(sym_in), .hold(hold),
        .pattern_in(pattern_in), .state_in(state_in), .state(state_b), .match(match_b),
        .match_pulse(pulse_b), .match_count(count_b), .count_sat(sat_b)
    );

    moore_seq_detect #(.SYM_W(2), .DEPTH(4), .CNT_W(8)) dut_c (
        .clk(clk), .reset(reset), .step(step), .sym_in(sym_in), .hold(hold),
        .pattern_in(pattern_in_c), .state_in(state_in_c), .state(state_c), .match(match_c),
        .match_pulse(pulse_c), .match_count(count_c), .count_sat(sat_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, let the edge pass, then sample 1 time unit later.
    task automatic apply(input logic rst, input logic stp, input logic [1:0] sy);
        reset  = rst;
        step   = stp;
        sym_in = sy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [1:0] st, input logic m,
                           input logic p, input logic [7:0] cnt);
        check({tag, ".state"}, 32'(state_a), 32'(st));
        check({tag, ".match"}, 32'(match_a), 32'(m));
        check({tag, ".pulse"}, 32'(pulse_a), 32'(p));
        check({tag, ".count"}, 32'(count_a), 32'(cnt));
    endtask

    initial begin
        reset = 1'b0; step = 1'b0; hold = 1'b1; sym_in = 2'd0;
        pattern_in   = {2'd3, 2'd2, 2'd1};
        pattern_in_c = {2'd0, 2'd3, 2'd2, 2'd1};
        state_in     = 2'd0;
        state_in_c   = 3'd0;

        apply(1'b1, 1'b0, 2'd0);
        check_a("reset", 2'd0, 1'b0, 1'b0, 8'd0);
        check("reset.sat", 32'(sat_a), 32'd0);
        // Pattern is latched only at reset; this change must have no effect.
        pattern_in = 6'd0;

        apply(1'b0, 1'b1, 2'd1); check_a("seq1", 2'd1, 1'b0, 1'b0, 8'd0);
        apply(1'b0, 1'b1, 2'd2); check_a("seq2", 2'd2, 1'b0, 1'b0, 8'd0);
        apply(1'b0, 1'b1, 2'd3); check_a("seq3", 2'd3, 1'b1, 1'b1, 8'd1);

        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 2'd3); check_a("hold_stay", 2'd3, 1'b1, 1'b0, 8'd1);
        end
        apply(1'b0, 1'b1, 2'd1); check_a("hold_exit", 2'd1, 1'b0, 1'b0, 8'd1);

        apply(1'b0, 1'b1, 2'd2); check_a("to_s2", 2'd2, 1'b0, 1'b0, 8'd1);
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b0, 2'(i)); check_a("idle", 2'd2, 1'b0, 1'b0, 8'd1);
        end

        hold = 1'b0;
        apply(1'b0, 1'b1, 2'd3); check_a("nh_enter", 2'd3, 1'b1, 1'b1, 8'd2);
        apply(1'b0, 1'b1, 2'd3); check_a("nh_exit", 2'd0, 1'b0, 1'b0, 8'd2);
        apply(1'b0, 1'b1, 2'd1);
        apply(1'b0, 1'b1, 2'd2); check_a("nh_s2", 2'd2, 1'b0, 1'b0, 8'd2);
        apply(1'b0, 1'b1, 2'd1); check_a("s2_fb1", 2'd1, 1'b0, 1'b0, 8'd2);
        apply(1'b0, 1'b1, 2'd2);
        apply(1'b0, 1'b1, 2'd0); check_a("s2_fb0", 2'd0, 1'b0, 1'b0, 8'd2);

        // Saturation on the CNT_W=2 instance.
        pattern_in = {2'd3, 2'd2, 2'd1};
        apply(1'b1, 1'b0, 2'd0);
        check("sat_rst.count", 32'(count_b), 32'd0);
        for (int n = 1; n <= 5; n++) begin
            apply(1'b0, 1'b1, 2'd1);
            apply(1'b0, 1'b1, 2'd2);
            apply(1'b0, 1'b1, 2'd3);
            check("sat.count_b", 32'(count_b), (n >= 3) ? 32'd3 : 32'(n));
            check("sat.sat_b", 32'(sat_b), (n >= 3) ? 32'd1 : 32'd0);
            check("sat.pulse_b", 32'(pulse_b), 32'd1);
            check("sat.count_a", 32'(count_a), 32'(n));
        end
        apply(1'b0, 1'b1, 2'd0);
        check("sat_keep.sat_b", 32'(sat_b), 32'd1);
        check("sat_keep.count_b", 32'(count_b), 32'd3);
        check("nosat.sat_a", 32'(sat_a), 32'd0);

        // Mid-sequence reset; 5 does not fit the 2-bit state_in, so the DEPTH=4 unit covers it.
        apply(1'b0, 1'b1, 2'd1);
        apply(1'b0, 1'b1, 2'd2);
        check("mid.state_c", 32'(state_c), 32'd2);
        state_in_c = 3'd5;
        apply(1'b1, 1'b1, 2'd3);
        check("rst5.state_c", 32'(state_c), 32'd0);
        check("rst5.match_c", 32'(match_c), 32'd0);
        check_a("rst_mid", 2'd0, 1'b0, 1'b0, 8'd0);
        state_in_c = 3'd4;
        state_in   = 2'd3;
        apply(1'b1, 1'b0, 2'd0);
        check_a("rst3", 2'd3, 1'b1, 1'b0, 8'd0);
        check("rst4.match_c", 32'(match_c), 32'd1);
        check("rst4.state_c", 32'(state_c), 32'd4);
        check("rst3.sat_b", 32'(sat_b), 32'd0);
        hold = 1'b1;
        apply(1'b0, 1'b1, 2'd3); check_a("loaded_stay", 2'd3, 1'b1, 1'b0, 8'd0);
        hold = 1'b0;
        apply(1'b0, 1'b1, 2'd3); check_a("loaded_exit", 2'd0, 1'b0, 1'b0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/moore_seq_detect.md
MOORE_SEQ_DETECT -- requirements
Module: moore_seq_detect

Interface
REQ-001 Parameter SYM_W, default 2, symbol width in bits (>=1).
REQ-002 Parameter DEPTH, default 3, pattern length in symbols (>=2).
REQ-003 Parameter CNT_W, default 8, match counter width (>=1).
REQ-004 Derived width ST_W = clog2(DEPTH+1), used for all state ports.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 step  input  1  advance enable; FSM evaluates sym_in only when high.
REQ-008 sym_in  input  SYM_W  current input symbol (board switches).
REQ-009 hold  input  1  mode; 1 = sticky match state, 0 = non-sticky.
REQ-010 pattern_in  input  DEPTH*SYM_W  target pattern; pat[k] = pattern_in[k*SYM_W +: SYM_W], k=0 first.
REQ-011 state_in  input  ST_W  initial state loaded at reset.
REQ-012 state  output  ST_W  registered FSM state = number of pattern symbols currently matched.
REQ-013 match  output  1  registered Moore output, high iff state == DEPTH.
REQ-014 match_pulse  output  1  registered, high for one cycle on each entry into state DEPTH.
REQ-015 match_count  output  CNT_W  registered count of entries into state DEPTH.
REQ-016 count_sat  output  1  registered, high once match_count has reached all-ones.

Function
REQ-017 The FSM SHALL have states 0..DEPTH; state k means pat[0..k-1] matched.
REQ-018 pattern_in SHALL be captured into an internal register only on reset cycles; later changes SHALL be ignored until the next reset.
REQ-019 With step=0 and reset=0, state, match, match_count and count_sat SHALL hold; match_pulse SHALL be 0.
REQ-020 From state k<DEPTH with step=1: sym_in==pat[k] -> k+1; otherwise sym_in==pat[0] -> 1; otherwise -> 0.
REQ-021 From state DEPTH with step=1 and hold=1: sym_in==pat[DEPTH-1] -> stay DEPTH; otherwise apply the fallback (pat[0] -> 1, else 0).
REQ-022 From state DEPTH with step=1 and hold=0: sym_in==pat[0] -> 1; otherwise -> 0.
REQ-023 match SHALL be registered from the next state on the same edge as state, so match == (state==DEPTH) on every cycle with zero lag.
REQ-024 match_pulse SHALL be 1 for the single cycle after an edge on which state moves from a value <DEPTH to DEPTH; remaining in DEPTH SHALL NOT pulse.
REQ-025 match_count SHALL increment by 1 on each match_pulse event and saturate at 2^CNT_W-1, never wrapping.
REQ-026 count_sat SHALL go high on the edge at which match_count becomes all-ones and stay high until reset.
REQ-027 hold changes SHALL take effect on the next step evaluation, with no other side effects.

Reset
REQ-028 On a reset cycle, state SHALL load state_in if state_in <= DEPTH, else 0.
REQ-029 On reset, match SHALL equal (loaded state == DEPTH); match_pulse, match_count and count_sat SHALL be 0.
REQ-030 Reset SHALL take priority over step; a reset asserted mid-sequence SHALL discard partial progress.
REQ-031 A state loaded as DEPTH at reset SHALL NOT count as an entry and SHALL NOT pulse.

Verification (SYM_W=2, DEPTH=3, pattern pat0=1, pat1=2, pat2=3, unless noted)
REQ-032 Reset with state_in=0, then step with sym 1,2,3 -> state 1,2,3; match=1 after the third edge; match_pulse high for one cycle; match_count=1.
REQ-033 hold=1, in state 3, step with sym=3 for 4 cycles -> state stays 3, no pulse, count stays 1; then sym=1 -> state 1, match=0.
REQ-034 hold=0, in state 3, step with sym=3 -> state 0; from state 2, step with sym=1 -> state 1; from state 2, step with sym=0 -> state 0.
REQ-035 step=0 while sym_in cycles 0..3 for 8 cycles -> state, match and count unchanged; match_pulse stays 0.
REQ-036 CNT_W=2: complete pattern 5 times with hold=0 -> match_count 1,2,3,3,3; count_sat rises with the third match and stays 1.
REQ-037 Reset mid-sequence with state_in=5 -> state 0; reset with state_in=3 -> match=1, match_pulse=0, match_count=0 on the first cycle after reset.
